bit_serial_alu_ctrl: RTL and testbench



---
 rtl/bit_alu_pkg.sv | 21 ++
 rtl/bit_alu_cell.sv | 37 +++
 rtl/bit_serial_alu_ctrl.sv | 148 ++++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_alu_pkg.sv
// Shared types for the bit-serial ALU controller and its 1-bit cell.
package bit_alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_alu_cell.sv
// One-bit ALU slice: AND, OR, or full-adder sum/carry selected by op.
module bit_alu_cell
  import bit_alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    out,
  output logic    cout
);

  logic and_bit;
  logic or_bit;
  logic sum_bit;
  logic fa_carry;

  assign and_bit  = a & b;
  assign or_bit   = a | b;
  assign sum_bit  = a ^ b ^ cin;
  assign fa_carry = (a & b) | (cin & (a ^ b));

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_AND: out = and_bit;
      OP_OR:  out = or_bit;
      OP_ADD, OP_SUB: begin
        out  = sum_bit;
        cout = fa_carry;
      end
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Sequences a WIDTH-bit AND/OR/ADD/SUB through one bit_alu_cell, LSB first.
// Define BIT_ALU_OVF_EN to add the signed-overflow output.
module bit_serial_alu_ctrl
  import bit_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
`ifdef BIT_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
`ifdef BIT_ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_out;
  logic             cell_cout;
  logic [WIDTH-1:0] result_shift;

  bit_alu_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .out  (cell_out),
    .cout (cell_cout)
  );

  // Each cell output enters at the MSB, so bit 0 lands at the LSB after WIDTH steps.
  assign result_shift = {cell_out, result_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
`ifdef BIT_ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d     = ST_RUN;
          op_d        = alu_op_e'(op);
          a_sh_d      = a;
          // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
          b_sh_d      = (alu_op_e'(op) == OP_SUB) ? ~b : b;
          carry_d     = (alu_op_e'(op) == OP_SUB);
          idx_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          zero_d      = 1'b0;
`ifdef BIT_ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        result_d = result_shift;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        idx_d    = idx_q + CNT_W'(1);
        if (is_arith(op_q)) begin
          carry_d = cell_cout;
        end
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          carry_out_d = is_arith(op_q) ? cell_cout : 1'b0;
          zero_d      = (result_shift == '0);
`ifdef BIT_ALU_OVF_EN
          // Final step is the MSB cell: overflow is carry-in xor carry-out there.
          ovf_d       = is_arith(op_q) ? (carry_q ^ cell_cout) : 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
`ifdef BIT_ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
`ifdef BIT_ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
`ifdef BIT_ALU_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Table-driven bench for bit_serial_alu_ctrl (WIDTH=8) plus multi-cycle corner sequences.
module tb_bit_serial_alu_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
`ifdef BIT_ALU_OVF_EN
  logic       overflow;
`endif

  int total = 0;
  int bad   = 0;

  bit_serial_alu_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
`ifdef BIT_ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Call just after a negedge: drives start for one cycle, then waits for done.
  // Returns at the negedge of the done cycle; lat counts cycles after the sampling edge.
  task automatic start_and_wait(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                output int lat, output int busy_cnt);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  int lat;
  int bc;
  int ndone;
  logic [7:0] cap;

  initial begin
    vecs[0] = '{op: 2'b00, a: 8'hF0, b: 8'h3C, res: 8'h30, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[1] = '{op: 2'b01, a: 8'h0F, b: 8'hF0, res: 8'hFF, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[2] = '{op: 2'b10, a: 8'hFF, b: 8'h01, res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};
    vecs[3] = '{op: 2'b10, a: 8'h7F, b: 8'h01, res: 8'h80, cout: 1'b0, zero: 1'b0, ovf: 1'b1};
    vecs[4] = '{op: 2'b11, a: 8'h05, b: 8'h07, res: 8'hFE, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[5] = '{op: 2'b11, a: 8'h07, b: 8'h05, res: 8'h02, cout: 1'b1, zero: 1'b0, ovf: 1'b0};
    vecs[6] = '{op: 2'b10, a: 8'h80, b: 8'h80, res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b1};
    vecs[7] = '{op: 2'b11, a: 8'h00, b: 8'h00, res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};
    vecs[8] = '{op: 2'b01, a: 8'h00, b: 8'h00, res: 8'h00, cout: 1'b0, zero: 1'b1, ovf: 1'b0};
    vecs[9] = '{op: 2'b10, a: 8'h12, b: 8'h34, res: 8'h46, cout: 1'b0, zero: 1'b0, ovf: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
`ifdef BIT_ALU_OVF_EN
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      start_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, 32'd9);
      chk($sformatf("v%0d_busy_cycles", i), bc, 32'd8);
      chk($sformatf("v%0d_busy_in_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_carry", i), {31'd0, carry_out}, {31'd0, vecs[i].cout});
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
`ifdef BIT_ALU_OVF_EN
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Outputs hold in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_result", {24'd0, result}, 32'h46);
    chk("hold_carry", {31'd0, carry_out}, 32'd0);
    chk("hold_zero", {31'd0, zero}, 32'd0);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 8'h0F; b = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h00; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap   = 8'h00;
    for (int c = 0; c < 16; c++) begin
      if (done) begin
        ndone++;
        cap = result;
        chk("busy_ign_zero", {31'd0, zero}, 32'd0);
      end
      @(negedge clk);
    end
    chk("busy_ign_ndone", ndone, 32'd1);
    chk("busy_ign_result", {24'd0, cap}, 32'hFF);

    // Reset three cycles into RUN.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h0F; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", {24'd0, result}, 32'd0);
    chk("mid_rst_carry", {31'd0, carry_out}, 32'd0);
    ndone = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", ndone, 32'd0);
    start_and_wait(2'b10, 8'h12, 8'h34, lat, bc);
    chk("post_rst_latency", lat, 32'd9);
    chk("post_rst_result", {24'd0, result}, 32'h46);

    // Back-to-back: new start during the DONE cycle.
    @(negedge clk);
    start_and_wait(2'b10, 8'h7F, 8'h01, lat, bc);
    chk("b2b_first_result", {24'd0, result}, 32'h80);
    start_and_wait(2'b00, 8'hAA, 8'h0F, lat, bc);
    chk("b2b_latency", lat, 32'd9);
    chk("b2b_busy_cycles", bc, 32'd8);
    chk("b2b_result", {24'd0, result}, 32'h0A);
    chk("b2b_carry", {31'd0, carry_out}, 32'd0);
    chk("b2b_zero", {31'd0, zero}, 32'd0);
`ifdef BIT_ALU_OVF_EN
    chk("b2b_ovf", {31'd0, overflow}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
